hit_storage_sequencer: RTL and testbench

Event-level controller in front of the hit storage block (HNM/HCM/HLM block-memory storage). It sequences each event through clear, load, drain and readout. In the load phase it round-robin arbitrates two hit sources onto the storage's single `newAddress`/`SSID`/`hitInfo` write port, gated by `storageReady`. It then hands a quiescent memory to the downstream readout logic.

---
 rtl/hit_storage_sequencer_pkg.sv | 21 ++
 rtl/hit_storage_sequencer_rr_arbiter2.sv | 24 ++
 rtl/hit_storage_sequencer.sv | 108 ++++++++++
 tb/tb_hit_storage_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_storage_sequencer_pkg.sv
// hit_storage_sequencer_pkg: shared storage parameters, state encoding and sizing helper
package hit_storage_sequencer_pkg;

    localparam int HS_SSIDBITS = 10;
    localparam int HS_HITINFOBITS = 8;
    localparam int NROWS_HNM = 1024;
    localparam int QUEUESIZE = 6;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        READOUT
    } seqState_t;

    function automatic int maxOf(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/hit_storage_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, combinational grant, registered preference pointer
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] request,
    output logic [1:0] grant
);

    logic pointer;

    // a lone request always wins; on contention the pointer picks the winner
    always_comb begin
        grant[0] = enable && request[0] && (!request[1] || !pointer);
        grant[1] = enable && request[1] && (!request[0] || pointer);
    end

    // after any grant the other source becomes preferred
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pointer <= 1'b0;
        else if (|grant) pointer <= grant[0];
    end

endmodule

// File: rtl/hit_storage_sequencer.sv
// hit_storage_sequencer: sequences each event through clear, load, drain and readout of the hit storage
module hit_storage_sequencer
    import hit_storage_sequencer_pkg::*;
#(
    parameter int SSIDBITS = HS_SSIDBITS,
    parameter int HITINFOBITS = HS_HITINFOBITS,
    parameter int CLEARCYCLES = NROWS_HNM / 2,
    parameter int DRAINCYCLES = QUEUESIZE + 2,
    parameter int COUNTBITS = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   eventStart,
    input  logic                   eventEnd,
    input  logic                   reqValid0,
    input  logic                   reqValid1,
    input  logic [SSIDBITS-1:0]    reqSSID0,
    input  logic [SSIDBITS-1:0]    reqSSID1,
    input  logic [HITINFOBITS-1:0] reqHitInfo0,
    input  logic [HITINFOBITS-1:0] reqHitInfo1,
    output logic                   reqReady0,
    output logic                   reqReady1,
    input  logic                   storageReady,
    output logic                   clearMemory,
    output logic                   newAddress,
    output logic [SSIDBITS-1:0]    SSID,
    output logic [HITINFOBITS-1:0] hitInfo,
    output logic                   readoutGrant,
    input  logic                   readoutDone,
    output logic                   busy,
    output logic [COUNTBITS-1:0]   hitCount,
    output logic                   overrun
);

    localparam int CNTW = $clog2(maxOf(CLEARCYCLES, DRAINCYCLES)) + 1;

    seqState_t state, nextState;
    logic [CNTW-1:0] cycleCount;
    logic endSeen, loadEnable, accept, clearDone, drainDone, startEvent;
    logic [1:0] grant;

    assign loadEnable = state == LOAD && storageReady;
    assign accept = |grant;
    assign reqReady0 = grant[0];
    assign reqReady1 = grant[1];
    assign busy = state != IDLE;
    assign startEvent = state == IDLE && eventStart;
    assign clearDone = cycleCount >= CNTW'(CLEARCYCLES - 1) && storageReady;
    assign drainDone = cycleCount == CNTW'(DRAINCYCLES - 1);

    rr_arbiter2 arbiter (
        .clock   (clock),
        .reset   (reset),
        .enable  (loadEnable),
        .request ({reqValid1, reqValid0}),
        .grant   (grant)
    );

    // event phase sequencing; an eventEnd seen during CLEAR skips LOAD entirely
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (eventStart) nextState = CLEAR;
            CLEAR:   if (clearDone) nextState = (endSeen || eventEnd) ? DRAIN : LOAD;
            LOAD:    if (eventEnd) nextState = DRAIN;
            DRAIN:   if (drainDone) nextState = READOUT;
            READOUT: if (readoutDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // state register and per-phase cycle counter, restarted on every phase change and saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cycleCount <= '0;
            endSeen <= 1'b0;
        end else begin
            state <= nextState;
            cycleCount <= (nextState != state) ? '0 : (&cycleCount ? cycleCount : cycleCount + 1'b1);
            endSeen <= state == CLEAR && (endSeen || eventEnd);
        end
    end

    // registered storage write port, readout handoff and event bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clearMemory <= 1'b0;
            newAddress <= 1'b0;
            SSID <= '0;
            hitInfo <= '0;
            readoutGrant <= 1'b0;
            hitCount <= '0;
            overrun <= 1'b0;
        end else begin
            clearMemory <= startEvent;
            newAddress <= accept;
            if (accept) begin
                SSID <= grant[1] ? reqSSID1 : reqSSID0;
                hitInfo <= grant[1] ? reqHitInfo1 : reqHitInfo0;
            end
            readoutGrant <= nextState == READOUT;
            hitCount <= startEvent ? '0 : ((accept && !(&hitCount)) ? hitCount + 1'b1 : hitCount);
            overrun <= overrun || (eventStart && state != IDLE);
        end
    end

endmodule

// File: tb/tb_hit_storage_sequencer.sv
// tb_hit_storage_sequencer: directed stimulus against a phase-level model of the sequencer
module tb_hit_storage_sequencer;

    localparam int SB = 10;
    localparam int HB = 8;
    localparam int CB = 16;
    localparam int CLR = 512;
    localparam int DRN = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic eventStart = 1'b0, eventEnd = 1'b0, readoutDone = 1'b0, storageReady = 1'b1;
    logic reqValid0 = 1'b0, reqValid1 = 1'b0;
    logic [SB-1:0] reqSSID0 = '0, reqSSID1 = '0;
    logic [HB-1:0] reqHitInfo0 = '0, reqHitInfo1 = '0;
    logic reqReady0, reqReady1, clearMemory, newAddress, readoutGrant, busy, overrun;
    logic [SB-1:0] SSID;
    logic [HB-1:0] hitInfo;
    logic [CB-1:0] hitCount;

    int checks = 0;
    int errors = 0;
    logic [SB-1:0] seen[$];
    logic [SB-1:0] want[$];

    hit_storage_sequencer #(
        .SSIDBITS(SB), .HITINFOBITS(HB), .CLEARCYCLES(CLR), .DRAINCYCLES(DRN), .COUNTBITS(CB)
    ) dut (
        .clock(clock), .reset(reset), .eventStart(eventStart), .eventEnd(eventEnd),
        .reqValid0(reqValid0), .reqValid1(reqValid1), .reqSSID0(reqSSID0), .reqSSID1(reqSSID1),
        .reqHitInfo0(reqHitInfo0), .reqHitInfo1(reqHitInfo1), .reqReady0(reqReady0), .reqReady1(reqReady1),
        .storageReady(storageReady), .clearMemory(clearMemory), .newAddress(newAddress), .SSID(SSID),
        .hitInfo(hitInfo), .readoutGrant(readoutGrant), .readoutDone(readoutDone), .busy(busy),
        .hitCount(hitCount), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // model: phase 0 idle, 1 clear, 2 load, 3 drain, 4 readout
    int mPhase, mCycles;
    bit mEndSeen, mPrefer1;
    bit eClear, eNew, eGrant, eOverrun, r0, r1, mayLoad;
    logic [SB-1:0] eSSID;
    logic [HB-1:0] eInfo;
    logic [CB-1:0] eCount;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            mPhase = 0; mCycles = 0; mEndSeen = 0; mPrefer1 = 0;
            eClear = 0; eNew = 0; eGrant = 0; eOverrun = 0; eSSID = '0; eInfo = '0; eCount = '0;
        end
        mayLoad = !reset && mPhase == 2 && storageReady;
        r1 = mayLoad && reqValid1 && (!reqValid0 || mPrefer1);
        r0 = mayLoad && reqValid0 && !r1;
        check("clearMemory", clearMemory, eClear);
        check("newAddress", newAddress, eNew);
        check("SSID", SSID, eSSID);
        check("hitInfo", hitInfo, eInfo);
        check("readoutGrant", readoutGrant, eGrant);
        check("busy", busy, mPhase != 0);
        check("hitCount", hitCount, eCount);
        check("overrun", overrun, eOverrun);
        check("reqReady0", reqReady0, r0);
        check("reqReady1", reqReady1, r1);
        if (newAddress) seen.push_back(SSID);
        if (!reset) begin
            eClear = mPhase == 0 && eventStart;
            eNew = r0 || r1;
            if (r0 || r1) begin
                eSSID = r1 ? reqSSID1 : reqSSID0;
                eInfo = r1 ? reqHitInfo1 : reqHitInfo0;
                mPrefer1 = r0;
                if (eCount != {CB{1'b1}}) eCount = eCount + 1;
            end
            if (eventStart && mPhase != 0) eOverrun = 1;
            case (mPhase)
                0: if (eventStart) begin mPhase = 1; mCycles = 0; mEndSeen = 0; eCount = '0; end
                1: begin
                    mCycles++;
                    if (eventEnd) mEndSeen = 1;
                    if (mCycles >= CLR && storageReady) begin mPhase = mEndSeen ? 3 : 2; mCycles = 0; end
                end
                2: if (eventEnd) begin mPhase = 3; mCycles = 0; end
                3: begin mCycles++; if (mCycles == DRN) mPhase = 4; end
                default: if (readoutDone) mPhase = 0;
            endcase
            eGrant = mPhase == 4;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseStart();
        eventStart = 1; tick(); eventStart = 0;
    endtask

    task automatic pulseEnd();
        eventEnd = 1; tick(); eventEnd = 0;
    endtask

    task automatic pulseDone();
        readoutDone = 1; tick(); readoutDone = 0;
    endtask

    task automatic sendHit(input int s, input logic [SB-1:0] id);
        bit done = 0;
        if (s == 1) begin reqValid1 = 1; reqSSID1 = id; reqHitInfo1 = id[7:0] ^ 8'h5A; end
        else begin reqValid0 = 1; reqSSID0 = id; reqHitInfo0 = id[7:0] ^ 8'hA5; end
        for (int i = 0; i < 2000 && !done; i++) begin
            #1;
            done = (s == 1) ? reqReady1 : reqReady0;
            tick();
        end
        reqValid0 = 0; reqValid1 = 0;
        check("hitAccepted", done, 1);
    endtask

    task automatic waitGrant(output int n);
        n = 0;
        while (!readoutGrant && n < 2000) begin tick(); n++; end
        check("grantReached", readoutGrant, 1);
    endtask

    task automatic checkSeen(input string name);
        check({name, "Count"}, seen.size(), want.size());
        for (int i = 0; i < want.size() && i < seen.size(); i++) check(name, seen[i], want[i]);
    endtask

    task automatic checkAllZero(input string name);
        check({name, "Outputs"}, {clearMemory, newAddress, SSID, hitInfo, readoutGrant, busy, overrun, reqReady0, reqReady1}, 0);
        check({name, "HitCount"}, hitCount, 0);
    endtask

    initial begin
        int n, i0, i1;
        bit g0, g1;
        logic [SB-1:0] a0[2], a1[2];
        repeat (2) tick();
        checkAllZero("reset");
        reset = 0;
        tick();

        // basic event: three hits from source 0
        seen.delete();
        pulseStart();
        check("clearPulseHigh", clearMemory, 1);
        tick();
        check("clearPulseLow", clearMemory, 0);
        sendHit(0, 10'h011);
        sendHit(0, 10'h022);
        sendHit(0, 10'h033);
        eventEnd = 1;
        tick();
        eventEnd = 0;
        waitGrant(n);
        check("grantLatency", n + 1, DRN + 1);
        check("basicHitCount", hitCount, 3);
        want = '{10'h011, 10'h022, 10'h033};
        checkSeen("basicOrder");
        // eventStart in READOUT is ignored
        pulseStart();
        check("overrunSet", overrun, 1);
        check("overrunStillGranted", readoutGrant, 1);
        pulseDone();
        check("idleAfterDone", busy, 0);

        // reset in the middle of LOAD
        pulseStart();
        sendHit(1, 10'h0F0);
        #2;
        reset = 1;
        #1;
        checkAllZero("midLoadReset");
        tick();
        tick();
        reset = 0;
        tick();

        // both sources contend; pointer starts at source 0
        seen.delete();
        pulseStart();
        a0 = '{10'h101, 10'h102};
        a1 = '{10'h201, 10'h202};
        i0 = 0; i1 = 0;
        for (int c = 0; c < 2000 && (i0 < 2 || i1 < 2); c++) begin
            reqValid0 = i0 < 2; reqSSID0 = a0[i0 < 2 ? i0 : 0]; reqHitInfo0 = reqSSID0[7:0] ^ 8'hA5;
            reqValid1 = i1 < 2; reqSSID1 = a1[i1 < 2 ? i1 : 0]; reqHitInfo1 = reqSSID1[7:0] ^ 8'h5A;
            #1;
            g0 = reqReady0; g1 = reqReady1;
            tick();
            if (g0) i0++;
            if (g1) i1++;
        end
        reqValid0 = 0; reqValid1 = 0;
        tick();
        want = '{10'h101, 10'h201, 10'h102, 10'h202};
        checkSeen("alternation");

        // storage back-pressure holds the hit
        storageReady = 0;
        reqValid0 = 1; reqSSID0 = 10'h155; reqHitInfo0 = 8'h55 ^ 8'hA5;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stallReady", reqReady0, 0);
            check("stallNoWrite", newAddress, 0);
            tick();
        end
        storageReady = 1;
        sendHit(0, 10'h155);
        check("heldHitWrite", newAddress, 1);
        check("heldHitSSID", SSID, 10'h155);
        pulseEnd();
        waitGrant(n);
        check("contendHitCount", hitCount, 5);
        pulseDone();

        // next event after an overrun runs normally
        pulseStart();
        check("nextClear", clearMemory, 1);
        sendHit(1, 10'h3AB);
        check("nextInfo", hitInfo, 8'hAB ^ 8'h5A);
        pulseEnd();
        waitGrant(n);
        check("nextHitCount", hitCount, 1);
        pulseDone();

        // eventEnd during CLEAR skips LOAD; a waiting source is never accepted
        seen.delete();
        reqValid0 = 1; reqSSID0 = 10'h2C2;
        pulseStart();
        repeat (10) tick();
        pulseEnd();
        waitGrant(n);
        check("clearEndHitCount", hitCount, 0);
        check("clearEndNoWrites", seen.size(), 0);
        reqValid0 = 0;
        pulseDone();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
